wb_stage: RTL and testbench
===========================

# wb_stage

Writeback stage of the five-stage MIPS pipeline: the M/W pipeline register plus the logic that produces the write port of the general register file. It latches the memory-stage results and selects and extends the write data. It drives `regwrite`/`wa`/`wd` into `grf` and exposes `pc8` for the commit trace. It also keeps a retired-instruction counter for the bench and debug.

## Interface
Parameters:
- none (encodings come from the shared package)

Ports:
- `clk`  in  1  pipeline clock
- `rst`  in  1  reset, asynchronous, active-high
- `en`  in  1  advance enable; 0 = hold W contents (stall)
- `clr`  in  1  synchronous flush; loads a bubble into W
- `m_valid`  in  1  M stage holds a real instruction
- `m_regwrite`  in  1  instruction writes a GPR
- `m_wa`  in  5  destination register
- `m_alu`  in  32  ALU result; bits [1:0] give the load byte offset
- `m_dm`  in  32  raw data-memory word
- `m_pc8`  in  32  instruction PC+8
- `m_wsel`  in  2  write-data source: 00 ALU, 01 memory, 10 PC+8, 11 reserved
- `m_ldtype`  in  3  load kind: 000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu; others reserved
- `w_valid`  out  1  W holds a real instruction
- `regwrite`  out  1  GRF write enable
- `wa`  out  5  GRF write address
- `wd`  out  32  GRF write data
- `pc8`  out  32  PC+8 of the instruction in W
- `retired`  out  32  count of instructions that entered W

## Operation
- W register fields: valid, regwrite, wa, alu, dm, pc8, wsel, ldtype.
- Update priority per posedge:
  - `rst` first (asynchronous).
  - `clr` next: bubble, meaning every W field is 0. `clr` overrides `en`=0.
  - `en`=1 next: load all M inputs. A load with `m_valid`=0 is also a bubble.
  - `en`=0 last: hold all fields.
- `regwrite` = valid & regwrite_r & (wa_r != 0). Writes to $0 are never issued.
- `wa`, `pc8`: straight from W fields.
- `w_valid` = valid field.
- `wd` is combinational from the W fields:
  - wsel 00: alu_r.
  - wsel 10: pc8_r.
  - wsel 11: 0.
  - wsel 01: extended load data, below.
- Load extension, little-endian lanes:
  - byte k = dm_r[8k+7:8k], with k = alu_r[1:0].
  - halfword h = dm_r[16h+15:16h], with h = alu_r[1]; alu_r[0] is ignored for halfwords.
  - lb and lh sign-extend; lbu and lhu zero-extend.
  - lw and reserved ldtype codes pass dm_r unchanged.
- `retired` increments by 1 on a posedge where `en`=1, `clr`=0 and `m_valid`=1. It wraps modulo 2^32 and never saturates.

## Timing
- Latency: M inputs present at posedge N appear on W outputs after posedge N, i.e. in cycle N+1.
- `wd` is valid in the same cycle as `regwrite`. `grf` samples both on the following posedge.
- Reset: all W fields 0, so `w_valid`, `regwrite`, `wa`, `wd`, `pc8` and `retired` are all 0. They are 0 immediately on `rst` assertion, without waiting for a clock edge.
- Stall (`en`=0) of any length: outputs stay constant and `retired` does not change. The held `regwrite` remains asserted, so `grf` rewrites the same value each stalled cycle; this is harmless.
- `rst` mid-stall or mid-flush: reset wins and state is lost.
- A simultaneous `clr` and `en`: the bubble loads and the counter is not incremented.

## Structure
- Shared package `mips_defs` holds:
  - the wsel constants WSEL_ALU, WSEL_MEM, WSEL_PC8;
  - the ldtype constants LD_W, LD_B, LD_BU, LD_H, LD_HU.
- One sub-module, `load_ext`: purely combinational, inputs (dm, offset[1:0], ldtype), output 32-bit data. It is reusable by a later M-stage forwarding path.
- Everything else is the W register and the output mux in `wb_stage`.

## Test plan
- Reset: assert `rst` asynchronously between clock edges with `m_valid`=1 driven → all outputs 0 immediately. Release, then clock once with no valid input → `retired`=0.
- ALU writeback:
  - m_wa=8, m_alu=0x12345678, wsel=00, en=1 → next cycle regwrite=1, wa=8, wd=0x12345678, retired=1.
  - Same with m_wa=0 → regwrite=0.
- Loads with m_dm=0x80FF7F01:
  - lb at offset 2 → wd=0xFFFFFFFF.
  - lbu at offset 3 → wd=0x00000080.
  - lb at offset 1 → wd=0x0000007F.
  - lh at alu=...2 → wd=0xFFFF80FF.
  - lhu at alu=...0 → wd=0x00007F01.
  - lh at alu=...1 → wd=0x00007F01.
- Link: wsel=10, m_pc8=0x00003008, m_wa=31 → wd=0x00003008, wa=31, pc8=0x00003008.
- Stall and flush:
  - Load a valid write, then hold en=0 for 3 cycles → outputs unchanged, retired unchanged.
  - Assert clr with en=0 → next cycle w_valid=0 and regwrite=0.
  - Assert clr with en=1 and m_valid=1 → bubble, retired unchanged.
- Counter wrap: force retired to 0xFFFFFFFF, then one valid advance → retired=0.

Source files
------------

// File: rtl/mips_defs.sv
// Shared encodings for the MIPS pipeline: writeback source select and load kinds.
// Also holds the packed layout of the M/W pipeline register.
package mips_defs;

  localparam logic [1:0] WSEL_ALU = 2'b00;
  localparam logic [1:0] WSEL_MEM = 2'b01;
  localparam logic [1:0] WSEL_PC8 = 2'b10;
  localparam logic [1:0] WSEL_RSV = 2'b11;

  localparam logic [2:0] LD_W  = 3'b000;
  localparam logic [2:0] LD_B  = 3'b001;
  localparam logic [2:0] LD_BU = 3'b010;
  localparam logic [2:0] LD_H  = 3'b011;
  localparam logic [2:0] LD_HU = 3'b100;

  // Contents of the W stage; an all-zero value is a bubble.
  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic [4:0]  wa;
    logic [31:0] alu;
    logic [31:0] dm;
    logic [31:0] pc8;
    logic [1:0]  wsel;
    logic [2:0]  ldtype;
  } w_reg_t;

endpackage

// File: rtl/load_ext.sv
// Selects the addressed byte/halfword lane of a little-endian memory word and extends it.
// Purely combinational so the M stage can reuse it for load forwarding.
module load_ext
  import mips_defs::*;
(
  input  logic [31:0] dm,
  input  logic [1:0]  offset,
  input  logic [2:0]  ldtype,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // NOTE: every signal written here gets a value before the case, so no path can infer a latch.
    byte_sel = dm[8*offset +: 8];
    half_sel = offset[1] ? dm[31:16] : dm[15:0];
    data     = dm;
    case (ldtype)
      LD_B:    data = {{24{byte_sel[7]}}, byte_sel};
      LD_BU:   data = {24'h0, byte_sel};
      LD_H:    data = {{16{half_sel[15]}}, half_sel};
      LD_HU:   data = {16'h0, half_sel};
      default: data = dm;  // lw and reserved codes pass the word through
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: M/W pipeline register, GRF write-port generation and a retired counter.
// Stall holds W, clr loads a bubble, and reset clears everything asynchronously.
module wb_stage
  import mips_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clr,
  input  logic        m_valid,
  input  logic        m_regwrite,
  input  logic [4:0]  m_wa,
  input  logic [31:0] m_alu,
  input  logic [31:0] m_dm,
  input  logic [31:0] m_pc8,
  input  logic [1:0]  m_wsel,
  input  logic [2:0]  m_ldtype,
  output logic        w_valid,
  output logic        regwrite,
  output logic [4:0]  wa,
  output logic [31:0] wd,
  output logic [31:0] pc8,
  output logic [31:0] retired
);

  w_reg_t      w_q;
  w_reg_t      m_word;
  logic [31:0] retired_q;
  logic [31:0] load_data;

  assign m_word = '{valid:    m_valid,
                    regwrite: m_regwrite,
                    wa:       m_wa,
                    alu:      m_alu,
                    dm:       m_dm,
                    pc8:      m_pc8,
                    wsel:     m_wsel,
                    ldtype:   m_ldtype};

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_q       <= '0;
      retired_q <= '0;
    end else if (clr) begin
      w_q <= '0;
    end else if (en) begin
      // An invalid M slot still loads as a full bubble, not a half-valid entry.
      w_q <= m_valid ? m_word : '0;
      if (m_valid) retired_q <= retired_q + 32'd1;
    end
  end

  load_ext u_load_ext (
    .dm     (w_q.dm),
    .offset (w_q.alu[1:0]),
    .ldtype (w_q.ldtype),
    .data   (load_data)
  );

  always_comb begin
    wd = '0;
    case (w_q.wsel)
      WSEL_ALU: wd = w_q.alu;
      WSEL_MEM: wd = load_data;
      WSEL_PC8: wd = w_q.pc8;
      default:  wd = '0;
    endcase
  end

  // $0 is hardwired; suppress the write here so grf never sees it.
  assign regwrite = w_q.valid & w_q.regwrite & (w_q.wa != 5'd0);
  assign w_valid  = w_q.valid;
  assign wa       = w_q.wa;
  assign pc8      = w_q.pc8;
  assign retired  = retired_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed cases plus randomized traffic
// compared against a behavioural model of the W stage.
module tb_wb_stage;

  logic        clk;
  logic        rst;
  logic        en;
  logic        clr;
  logic        m_valid;
  logic        m_regwrite;
  logic [4:0]  m_wa;
  logic [31:0] m_alu;
  logic [31:0] m_dm;
  logic [31:0] m_pc8;
  logic [1:0]  m_wsel;
  logic [2:0]  m_ldtype;
  logic        w_valid;
  logic        regwrite;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [31:0] pc8;
  logic [31:0] retired;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the instruction sitting in W plus the retire count.
  logic        mdl_valid;
  logic        mdl_rw;
  logic [4:0]  mdl_wa;
  logic [31:0] mdl_alu;
  logic [31:0] mdl_dm;
  logic [31:0] mdl_pc8;
  logic [1:0]  mdl_wsel;
  logic [2:0]  mdl_ldt;
  logic [31:0] mdl_retired;

  wb_stage dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .clr        (clr),
    .m_valid    (m_valid),
    .m_regwrite (m_regwrite),
    .m_wa       (m_wa),
    .m_alu      (m_alu),
    .m_dm       (m_dm),
    .m_pc8      (m_pc8),
    .m_wsel     (m_wsel),
    .m_ldtype   (m_ldtype),
    .w_valid    (w_valid),
    .regwrite   (regwrite),
    .wa         (wa),
    .wd         (wd),
    .pc8        (pc8),
    .retired    (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Expected write data straight from the ISA semantics of each load kind.
  function automatic logic [31:0] exp_wd();
    int unsigned bsel;
    int unsigned hsel;
    byte         sb;
    shortint     sh;
    bsel = (mdl_dm >> (8 * mdl_alu[1:0])) & 32'hFF;
    hsel = (mdl_dm >> (16 * mdl_alu[1])) & 32'hFFFF;
    sb   = byte'(bsel);
    sh   = shortint'(hsel);
    case (mdl_wsel)
      2'd0: return mdl_alu;
      2'd2: return mdl_pc8;
      2'd3: return 32'd0;
      default: begin
        case (mdl_ldt)
          3'd1:    return 32'(int'(sb));
          3'd2:    return bsel;
          3'd3:    return 32'(int'(sh));
          3'd4:    return hsel;
          default: return mdl_dm;
        endcase
      end
    endcase
  endfunction

  task automatic model_clear();
    mdl_valid = 0; mdl_rw = 0; mdl_wa = 0; mdl_alu = 0;
    mdl_dm = 0; mdl_pc8 = 0; mdl_wsel = 0; mdl_ldt = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".w_valid"},  32'(w_valid),  32'(mdl_valid));
    check({tag, ".regwrite"}, 32'(regwrite), 32'(mdl_valid && mdl_rw && mdl_wa != 0));
    check({tag, ".wa"},       32'(wa),       32'(mdl_wa));
    check({tag, ".wd"},       wd,            exp_wd());
    check({tag, ".pc8"},      pc8,           mdl_pc8);
    check({tag, ".retired"},  retired,       mdl_retired);
  endtask

  task automatic drive_m(input logic v, input logic rw, input logic [4:0] a,
                         input logic [31:0] alu, input logic [31:0] dm,
                         input logic [31:0] p8, input logic [1:0] ws, input logic [2:0] lt);
    m_valid = v; m_regwrite = rw; m_wa = a; m_alu = alu;
    m_dm = dm; m_pc8 = p8; m_wsel = ws; m_ldtype = lt;
  endtask

  // One clock: the model applies the same priority rules the stage must follow.
  task automatic tick(input string tag);
    @(posedge clk);
    if (clr) begin
      model_clear();
    end else if (en) begin
      if (m_valid) begin
        mdl_valid = 1; mdl_rw = m_regwrite; mdl_wa = m_wa; mdl_alu = m_alu;
        mdl_dm = m_dm; mdl_pc8 = m_pc8; mdl_wsel = m_wsel; mdl_ldt = m_ldtype;
        mdl_retired = mdl_retired + 1;
      end else begin
        model_clear();
      end
    end
    #1;
    check_outputs(tag);
  endtask

  // Reset asserted between edges must clear outputs without a clock.
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_clear();
    mdl_retired = 0;
    check_outputs(tag);
    #1 rst = 1'b0;
  endtask

  task automatic load_case(input string tag, input logic [2:0] lt, input logic [31:0] alu,
                           input logic [31:0] exp);
    en = 1; clr = 0;
    drive_m(1, 1, 5'd9, alu, 32'h80FF7F01, 32'h100, 2'b01, lt);
    tick(tag);
    check({tag, ".literal"}, wd, exp);
  endtask

  initial begin
    rst = 1; en = 1; clr = 0;
    drive_m(1, 1, 5'd3, 32'hDEAD_BEEF, 32'h0, 32'h0, 2'b00, 3'b000);
    model_clear();
    mdl_retired = 0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset_held");
    rst = 0;

    // Load something, then reset mid-cycle with a valid M input driven.
    tick("pre_reset_load");
    async_reset("async_reset");
    drive_m(0, 1, 5'd3, 32'h1, 32'h0, 32'h0, 2'b00, 3'b000);
    tick("post_reset_idle");
    check("post_reset_retired", retired, 32'd0);

    // ALU writeback and the $0 suppression.
    drive_m(1, 1, 5'd8, 32'h12345678, 32'h0, 32'h0, 2'b00, 3'b000);
    tick("alu_wb");
    check("alu_wb.regwrite_lit", 32'(regwrite), 32'd1);
    check("alu_wb.retired_lit", retired, 32'd1);
    drive_m(1, 1, 5'd0, 32'h12345678, 32'h0, 32'h0, 2'b00, 3'b000);
    tick("alu_wb_r0");
    check("alu_wb_r0.regwrite_lit", 32'(regwrite), 32'd0);

    load_case("lb_off2",  3'b001, 32'h1002, 32'hFFFFFFFF);
    load_case("lbu_off3", 3'b010, 32'h1003, 32'h00000080);
    load_case("lb_off1",  3'b001, 32'h1001, 32'h0000007F);
    load_case("lh_off2",  3'b011, 32'h1002, 32'hFFFF80FF);
    load_case("lhu_off0", 3'b100, 32'h1000, 32'h00007F01);
    load_case("lh_off1",  3'b011, 32'h1001, 32'h00007F01);
    load_case("lw",       3'b000, 32'h1000, 32'h80FF7F01);
    load_case("ld_rsv",   3'b111, 32'h1003, 32'h80FF7F01);

    // Link writeback.
    drive_m(1, 1, 5'd31, 32'h5, 32'h0, 32'h00003008, 2'b10, 3'b000);
    tick("link");
    check("link.wd_lit", wd, 32'h00003008);
    check("link.wa_lit", 32'(wa), 32'd31);

    // Reserved wsel produces zero.
    drive_m(1, 1, 5'd4, 32'hFFFF, 32'hFFFF, 32'hFFFF, 2'b11, 3'b000);
    tick("wsel_rsv");

    // Stall three cycles with new M traffic present.
    drive_m(1, 1, 5'd12, 32'hCAFE0000, 32'h0, 32'h44, 2'b00, 3'b000);
    tick("stall_load");
    en = 0;
    for (int i = 0; i < 3; i++) begin
      drive_m(1, 1, 5'(i + 1), $urandom, $urandom, $urandom, 2'b00, 3'b000);
      tick($sformatf("stall_%0d", i));
      check($sformatf("stall_%0d.wd_lit", i), wd, 32'hCAFE0000);
    end

    // Flush overrides a stall, and flush with advance does not count.
    clr = 1; en = 0;
    tick("clr_stall");
    drive_m(1, 1, 5'd12, 32'h1, 32'h0, 32'h0, 2'b00, 3'b000);
    tick("reload_dummy");
    clr = 1; en = 1;
    drive_m(1, 1, 5'd7, 32'h77, 32'h0, 32'h0, 2'b00, 3'b000);
    tick("clr_en");
    clr = 0;

    // Counter wrap from the all-ones value.
    @(negedge clk);
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    mdl_retired = 32'hFFFF_FFFF;
    en = 1;
    drive_m(1, 0, 5'd2, 32'h0, 32'h0, 32'h0, 2'b00, 3'b000);
    tick("wrap");
    check("wrap.retired_lit", retired, 32'd0);

    // Randomized traffic, occasionally stalled, flushed or reset.
    for (int i = 0; i < 400; i++) begin
      en  = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 9) == 0);
      drive_m(($urandom_range(0, 4) != 0), $urandom_range(0, 1), 5'($urandom_range(0, 31)),
              $urandom, $urandom, $urandom, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
      tick($sformatf("rand_%0d", i));
      if ($urandom_range(0, 59) == 0) async_reset($sformatf("rand_rst_%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
